hdr_fifo_rr_arbiter: RTL and testbench
======================================

Name: hdr_fifo_rr_arbiter

Overview:
Round-robin read scheduler that drains up to N_CHAN per-channel header FIFOs (108-bit entries, registered read data) into one shared header stream toward the readout/packetiser. It issues exactly one rd_en pulse per grant and waits a fixed read latency. It then captures the header, tags it with the source channel, and presents it on a valid/ready output. A free-running count of forwarded headers is exported for status registers.

Parameters:
N_CHAN, 4, number of header FIFOs arbitrated (2..16)
HDR_W, 108, header word width
RD_LAT, 2, cycles from rd_en pulse to valid FIFO dout (FIFO read plus output register); legal 1..7
CH_W, $clog2(N_CHAN), channel index width (derived, not overridable)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  arbitration enable; sampled only in IDLE
fifo_empty  in  N_CHAN  per-channel FIFO empty flags
fifo_dout  in  N_CHAN*HDR_W  per-channel FIFO read data; channel i at [i*HDR_W +: HDR_W]
fifo_rd_en  out  N_CHAN  per-channel read strobes, at most one bit high
out_valid  out  1  header available
out_ready  in  1  downstream accepts header
out_hdr  out  HDR_W  captured header
out_chan  out  CH_W  source channel of out_hdr
busy  out  1  high in any state except IDLE
hdr_count  out  32  headers accepted downstream since reset; wraps at 2^32

Behaviour:
- Reset is asynchronous and active-low. With rst_n low: state=IDLE, fifo_rd_en=0, out_valid=0, out_hdr=0, out_chan=0, busy=0, hdr_count=0, rr_ptr=0, latency counter=0.
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE: if enable and any ~fifo_empty bit is set, grant the first non-empty channel searching rr_ptr, rr_ptr+1, ... modulo N_CHAN. Latch grant index g. Go to ISSUE. Otherwise stay in IDLE.
- ISSUE (one cycle): fifo_rd_en[g]=1 (registered output, high for exactly this cycle). Load lat_cnt=RD_LAT-1. Go to WAIT.
- WAIT: decrement lat_cnt each cycle. When lat_cnt==0, capture out_hdr<=fifo_dout[g], out_chan<=g, out_valid<=1, and go to HOLD.
  - The capture edge is RD_LAT cycles after the edge at which rd_en was sampled high.
  - With RD_LAT=1, WAIT lasts one cycle.
- HOLD: out_hdr and out_chan are stable while out_valid=1. On out_valid&out_ready: out_valid<=0, hdr_count+=1, rr_ptr<=(g+1) mod N_CHAN, go to IDLE.
- Minimum grant-to-grant period is RD_LAT+3 cycles (IDLE, ISSUE, WAIT×RD_LAT, HOLD with ready=1). There is no back-to-back pipelining by design.
- The empty flag is checked only in IDLE, so a granted FIFO is never read while empty. fifo_empty changes after grant are ignored.
- If enable deasserts mid-transaction, the transaction completes. The new value takes effect in IDLE.
- rr_ptr advances only on completed transfer; a stalled out_ready therefore does not starve other channels' fairness order.
- Non-power-of-2 N_CHAN: pointer wrap uses explicit compare with N_CHAN-1, not bit truncation.
- Reset asserted in any state: outputs return immediately to reset values. A read already issued is lost, and the FIFO entry is consumed. This is accepted as a reset-only loss.
- hdr_count wraps from 0xFFFFFFFF to 0 with no flag.

Decomposition:
- Shared package (hdr_arb_pkg):
  - state enum {IDLE, ISSUE, WAIT, HOLD}, 2 bits
  - HDR_W default constant
  - function rr_next(ptr, req) returning first set index at or after ptr
- One sub-module is natural: rr_priority_pick. It is purely combinational, takes req[N_CHAN] and ptr[CH_W], and returns grant_idx and grant_any. This keeps the FSM file small and lets the picker be unit-tested exhaustively.

Test Plan:
- Single channel: N_CHAN=4, RD_LAT=2, only ch2 non-empty with dout=108'hABC, out_ready=1. Expect fifo_rd_en=4'b0100 for exactly 1 cycle; out_valid 3 cycles later with out_hdr=108'hABC, out_chan=2; hdr_count=1.
- Fairness: all 4 channels non-empty continuously, out_ready=1. Expect grant order 0,1,2,3,0,1… with a period of 5 cycles, and no two rd_en bits ever high together.
- Backpressure: hold out_ready=0 for 10 cycles while in HOLD. Expect out_hdr and out_chan constant, no rd_en pulses, busy=1. After ready rises: 1 transfer, then the next grant goes to g+1.
- Skip empties: rr_ptr=1, only ch0 and ch3 non-empty. Expect grant 3, then 0, then 3.
- Reset mid-op: pull rst_n low during WAIT. Expect out_valid=0, fifo_rd_en=0, hdr_count=0 immediately without a clock edge; after release, grant restarts from ch0.
- Enable/empty edge: enable=0 with ch1 non-empty → no rd_en for 20 cycles. Set enable=1 → grant in the next IDLE evaluation. Set fifo_empty[1]=1 during WAIT → capture still completes.

Source files
------------

// File: rtl/hdr_fifo_rr_arbiter_pkg.sv
// Shared types and helpers for the header FIFO round-robin arbiter.
package hdr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } arb_state_t;

    localparam int unsigned HDR_W_DEF = 108;
    localparam int unsigned MAX_CHAN  = 16;

    // First set request at or after ptr, wrapping modulo n_chan.
    // Scans from farthest to nearest so the closest hit is the last one assigned.
    function automatic int unsigned rr_next(input int unsigned ptr,
                                            input logic [MAX_CHAN-1:0] req,
                                            input int unsigned n_chan);
        int unsigned idx;
        rr_next = ptr;
        for (int unsigned k = MAX_CHAN; k > 0; k--) begin
            if (k <= n_chan) begin
                idx = ptr + k - 1;
                if (idx >= n_chan) idx = idx - n_chan;
                if (req[idx[3:0]]) rr_next = idx;
            end
        end
    endfunction

endpackage

// File: rtl/hdr_fifo_rr_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first requesting channel at or after ptr.
module rr_priority_pick
    import hdr_arb_pkg::*;
#(
    parameter  int unsigned N_CHAN = 4,
    localparam int unsigned CH_W   = $clog2(N_CHAN)
) (
    input  logic [N_CHAN-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   grant_idx,
    output logic              grant_any
);

    logic [MAX_CHAN-1:0] req_ext;

    always_comb begin
        req_ext               = '0;
        req_ext[N_CHAN-1:0]   = req;
        grant_idx             = CH_W'(rr_next(32'(ptr), req_ext, N_CHAN));
        grant_any             = |req;
    end

endmodule

// File: rtl/hdr_fifo_rr_arbiter.sv
// Round-robin drain of per-channel header FIFOs into one tagged valid/ready
// header stream, one fixed-latency read per grant.
module hdr_fifo_rr_arbiter
    import hdr_arb_pkg::*;
#(
    parameter  int unsigned N_CHAN = 4,
    parameter  int unsigned HDR_W  = HDR_W_DEF,
    parameter  int unsigned RD_LAT = 2,
    localparam int unsigned CH_W   = $clog2(N_CHAN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [N_CHAN-1:0]        fifo_empty,
    input  logic [N_CHAN*HDR_W-1:0]  fifo_dout,
    output logic [N_CHAN-1:0]        fifo_rd_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [HDR_W-1:0]         out_hdr,
    output logic [CH_W-1:0]          out_chan,
    output logic                     busy,
    output logic [31:0]              hdr_count
);

    arb_state_t        state, state_next;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant;
    logic [2:0]        lat_cnt;

    logic [CH_W-1:0]   pick_idx;
    logic              pick_any;
    logic [N_CHAN-1:0] pick_onehot;
    logic [HDR_W-1:0]  sel_hdr;

    logic              do_grant;
    logic              do_capture;
    logic              do_accept;

    rr_priority_pick #(
        .N_CHAN (N_CHAN)
    ) u_pick (
        .req       (~fifo_empty),
        .ptr       (rr_ptr),
        .grant_idx (pick_idx),
        .grant_any (pick_any)
    );

    always_comb begin
        pick_onehot           = '0;
        pick_onehot[pick_idx] = 1'b1;
    end

    always_comb begin
        sel_hdr = '0;
        for (int unsigned i = 0; i < N_CHAN; i++) begin
            if (grant == CH_W'(i)) sel_hdr = fifo_dout[i*HDR_W +: HDR_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_capture = 1'b0;
        do_accept  = 1'b0;
        case (state)
            IDLE: begin
                if (enable && pick_any) begin
                    do_grant   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (lat_cnt == '0) begin
                    do_capture = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    do_accept  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_rd_en <= '0;
            grant      <= '0;
            rr_ptr     <= '0;
            lat_cnt    <= '0;
            out_valid  <= 1'b0;
            out_hdr    <= '0;
            out_chan   <= '0;
            hdr_count  <= '0;
        end else begin
            // Strobe is registered so it is high exactly while in ISSUE.
            fifo_rd_en <= do_grant ? pick_onehot : '0;
            if (do_grant) grant <= pick_idx;

            if (state == ISSUE)                      lat_cnt <= 3'(RD_LAT - 1);
            else if (state == WAIT && lat_cnt != '0) lat_cnt <= lat_cnt - 3'd1;

            if (do_capture) begin
                out_hdr   <= sel_hdr;
                out_chan  <= grant;
                out_valid <= 1'b1;
            end

            if (do_accept) begin
                out_valid <= 1'b0;
                hdr_count <= hdr_count + 32'd1;
                rr_ptr    <= (grant == CH_W'(N_CHAN - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hdr_fifo_rr_arbiter.sv
// Self-checking bench: FIFO model with 2-cycle registered read, scoreboard of
// expected {chan, hdr} popped on each downstream handshake.
module tb_hdr_fifo_rr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 108;
    localparam int unsigned L  = 2;
    localparam int unsigned CW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             enable = 1'b0;
    logic [N-1:0]     fifo_empty;
    logic [N*W-1:0]   fifo_dout;
    logic [N-1:0]     fifo_rd_en;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_hdr;
    logic [CW-1:0]    out_chan;
    logic             busy;
    logic [31:0]      hdr_count;

    int checks = 0;
    int passed = 0;
    int onehot_err = 0;
    int cyc = 0;

    logic [W-1:0]     mem [N][32];
    logic [31:0]      wp [N];
    logic [31:0]      rp [N];
    logic [W-1:0]     stage [N];
    logic [W-1:0]     dout_r [N];
    logic [N-1:0]     empty_force = '0;

    logic [CW+W-1:0]  sb [$];
    int               glog_chan [$];
    int               glog_cyc [$];

    hdr_fifo_rr_arbiter #(
        .N_CHAN (N),
        .HDR_W  (W),
        .RD_LAT (L)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_hdr    (out_hdr),
        .out_chan   (out_chan),
        .busy       (busy),
        .hdr_count  (hdr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < N; i++) begin
            wp[i] = '0;
            rp[i] = '0;
            stage[i] = '0;
            dout_r[i] = '0;
        end
    end

    // FIFO model: pop on sampled rd_en, data appears on dout two edges later.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (fifo_rd_en[i]) begin
                stage[i] <= mem[i][rp[i][4:0]];
                rp[i]    <= rp[i] + 32'd1;
            end
            dout_r[i] <= stage[i];
        end
    end

    always_comb begin
        fifo_empty = '0;
        fifo_dout  = '0;
        for (int i = 0; i < N; i++) begin
            fifo_empty[i]        = (wp[i] == rp[i]) | empty_force[i];
            fifo_dout[i*W +: W]  = dout_r[i];
        end
    end

    // Monitor: grant log, one-hot check, scoreboard compare on handshake.
    always @(negedge clk) begin
        logic [CW+W-1:0] exp_v;
        #2;
        if (rst_n) begin
            if (fifo_rd_en != '0) begin
                if ($onehot(fifo_rd_en)) begin
                    for (int i = 0; i < N; i++)
                        if (fifo_rd_en[i]) begin
                            glog_chan.push_back(i);
                            glog_cyc.push_back(cyc);
                        end
                end else begin
                    onehot_err = onehot_err + 1;
                end
            end
            if (out_valid && out_ready) begin
                checks = checks + 1;
                if (sb.size() == 0) begin
                    $display("FAIL sb_unexpected: got chan=%0d hdr=%h, no entry expected", out_chan, out_hdr);
                end else begin
                    exp_v = sb.pop_front();
                    if ({out_chan, out_hdr} !== exp_v)
                        $display("FAIL sb_data: got chan=%0d hdr=%h, expected chan=%0d hdr=%h",
                                 out_chan, out_hdr, exp_v[CW+W-1:W], exp_v[W-1:0]);
                    else
                        passed = passed + 1;
                end
            end
        end
    end

    task automatic push(input int ch, input logic [W-1:0] data, input bit expect_out);
        mem[ch][wp[ch][4:0]] = data;
        wp[ch] = wp[ch] + 32'd1;
        if (expect_out) sb.push_back({CW'(ch), data});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        glog_chan.delete();
        glog_cyc.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input int max_cyc, input string name);
        int t = 0;
        while ((sb.size() != 0 || busy) && t < max_cyc) begin
            @(negedge clk);
            t++;
        end
        if (t >= max_cyc) begin
            checks = checks + 1;
            $display("FAIL %s_drain: timeout, sb=%0d busy=%0b, required sb=0 busy=0", name, sb.size(), busy);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({fifo_rd_en, out_valid, busy, out_chan} !== '0)
            $display("FAIL reset_ctrl: rd_en=%b valid=%b busy=%b chan=%0d, required all 0", fifo_rd_en, out_valid, busy, out_chan);
        else passed++;
        checks++;
        if (out_hdr !== '0) $display("FAIL reset_hdr: got %h, required 0", out_hdr);
        else passed++;
        checks++;
        if (hdr_count !== 32'd0) $display("FAIL reset_count: got %0d, required 0", hdr_count);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int t = 0;
        do_reset();
        enable = 1'b1;
        out_ready = 1'b1;
        push(2, 108'hABC, 1'b1);
        while (fifo_rd_en == '0 && t < 20) begin @(negedge clk); t++; end
        checks++;
        if (fifo_rd_en !== 4'b0100) $display("FAIL single_rd_en: got %b, required 0100", fifo_rd_en);
        else passed++;
        @(negedge clk);
        checks++;
        if (fifo_rd_en !== 4'b0000 || out_valid !== 1'b0)
            $display("FAIL single_rd_pulse: rd_en=%b valid=%b, required 0000/0", fifo_rd_en, out_valid);
        else passed++;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL single_early_valid: got %b, required 0", out_valid);
        else passed++;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) $display("FAIL single_valid_lat: got %b, required 1", out_valid);
        else passed++;
        @(negedge clk);
        checks++;
        if (hdr_count !== 32'd1 || out_valid !== 1'b0)
            $display("FAIL single_count: count=%0d valid=%b, required 1/0", hdr_count, out_valid);
        else passed++;
        wait_drain(20, "single");
    endtask

    task automatic test_fairness();
        int bad_period = 0;
        do_reset();
        enable = 1'b1;
        out_ready = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < N; c++)
                push(c, W'(32'h100 + c * 16 + r), 1'b1);
        wait_drain(300, "fair");
        checks++;
        if (glog_chan.size() != 12) $display("FAIL fair_grants: got %0d grants, required 12", glog_chan.size());
        else passed++;
        for (int k = 0; k < glog_chan.size(); k++) begin
            checks++;
            if (glog_chan[k] != k % 4) $display("FAIL fair_order[%0d]: got ch%0d, required ch%0d", k, glog_chan[k], k % 4);
            else passed++;
            if (k > 0 && glog_cyc[k] - glog_cyc[k-1] != L + 3) bad_period++;
        end
        checks++;
        if (bad_period != 0) $display("FAIL fair_period: %0d gaps not equal, required all %0d cycles", bad_period, L + 3);
        else passed++;
        checks++;
        if (onehot_err != 0) $display("FAIL fair_onehot: %0d multi-bit rd_en, required 0", onehot_err);
        else passed++;
    endtask

    task automatic test_backpressure();
        int t = 0;
        int n_rd;
        bit stable = 1'b1;
        logic [W-1:0]  h;
        logic [CW-1:0] c;
        do_reset();
        enable = 1'b1;
        out_ready = 1'b0;
        push(1, 108'hA1, 1'b1);
        push(2, 108'hB2, 1'b1);
        push(1, 108'hA1B, 1'b1);
        while (!out_valid && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd1)
            $display("FAIL bp_first: valid=%b chan=%0d, required 1/1", out_valid, out_chan);
        else passed++;
        h = out_hdr;
        c = out_chan;
        n_rd = glog_chan.size();
        repeat (10) begin
            @(negedge clk);
            if (out_hdr !== h || out_chan !== c || busy !== 1'b1 || out_valid !== 1'b1) stable = 1'b0;
        end
        checks++;
        if (!stable) $display("FAIL bp_stable: hdr/chan/busy/valid changed, required constant");
        else passed++;
        checks++;
        if (glog_chan.size() != n_rd) $display("FAIL bp_no_rd: %0d reads during stall, required 0", glog_chan.size() - n_rd);
        else passed++;
        out_ready = 1'b1;
        wait_drain(100, "bp");
        checks++;
        if (glog_chan.size() != 3 || glog_chan[1] != 2 || glog_chan[2] != 1)
            $display("FAIL bp_order: %0d grants, 2nd=ch%0d, required 3 grants 1,2,1",
                     glog_chan.size(), (glog_chan.size() > 1) ? glog_chan[1] : -1);
        else passed++;
    endtask

    task automatic test_skip_empties();
        do_reset();
        enable = 1'b1;
        out_ready = 1'b1;
        push(0, 108'h50, 1'b1);
        wait_drain(50, "skip_warm");
        glog_chan.delete();
        glog_cyc.delete();
        push(3, 108'h3A, 1'b1);
        push(0, 108'h0B, 1'b1);
        push(3, 108'h3C, 1'b1);
        wait_drain(100, "skip");
        checks++;
        if (glog_chan.size() != 3 || glog_chan[0] != 3 || glog_chan[1] != 0 || glog_chan[2] != 3)
            $display("FAIL skip_order: %0d grants, first=ch%0d, required 3,0,3",
                     glog_chan.size(), (glog_chan.size() > 0) ? glog_chan[0] : -1);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int t = 0;
        do_reset();
        enable = 1'b1;
        out_ready = 1'b1;
        push(1, 108'h11, 1'b1);
        wait_drain(50, "rmid_warm");
        push(2, 108'hDEAD, 1'b0);
        while (fifo_rd_en == '0 && t < 20) begin @(negedge clk); t++; end
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || fifo_rd_en !== '0 || busy !== 1'b0)
            $display("FAIL rmid_outputs: valid=%b rd_en=%b busy=%b, required 0", out_valid, fifo_rd_en, busy);
        else passed++;
        checks++;
        if (hdr_count !== 32'd0) $display("FAIL rmid_count: got %0d, required 0", hdr_count);
        else passed++;
        sb.delete();
        glog_chan.delete();
        glog_cyc.delete();
        push(0, 108'hC0, 1'b1);
        push(3, 108'hC3, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_drain(100, "rmid");
        checks++;
        if (glog_chan.size() != 2 || glog_chan[0] != 0 || glog_chan[1] != 3)
            $display("FAIL rmid_restart: %0d grants, first=ch%0d, required 0 then 3",
                     glog_chan.size(), (glog_chan.size() > 0) ? glog_chan[0] : -1);
        else passed++;
    endtask

    task automatic test_enable_empty();
        int t = 0;
        do_reset();
        enable = 1'b0;
        out_ready = 1'b1;
        push(1, 108'hE1, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (glog_chan.size() != 0 || busy !== 1'b0)
            $display("FAIL en_hold: %0d grants busy=%b while disabled, required 0/0", glog_chan.size(), busy);
        else passed++;
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (fifo_rd_en !== 4'b0010) $display("FAIL en_grant: rd_en=%b, required 0010", fifo_rd_en);
        else passed++;
        @(negedge clk);
        empty_force[1] = 1'b1;
        enable = 1'b0;
        while (!out_valid && t < 20) begin @(negedge clk); t++; end
        checks++;
        if (out_valid !== 1'b1) $display("FAIL en_capture: valid=%b, required 1", out_valid);
        else passed++;
        wait_drain(20, "en");
        empty_force = '0;
        repeat (5) @(negedge clk);
        checks++;
        if (hdr_count !== 32'd1 || glog_chan.size() != 1)
            $display("FAIL en_count: count=%0d grants=%0d, required 1/1", hdr_count, glog_chan.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_skip_empties();
        test_reset_mid();
        test_enable_empty();
        checks++;
        if (onehot_err != 0) $display("FAIL onehot_total: %0d multi-bit rd_en, required 0", onehot_err);
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $display("%0d/%0d checks passed", passed, checks + 1);
        $fatal(1);
    end

endmodule
